// File: rtl/mask_gen_sequencer_if.sv
// Signal bundle between the mask generator sequencer and its neighbours:
// the config source, the mask generator and the downstream row consumer.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The config side holds its fields stable while cfg_valid is
// high and not yet accepted. The row side holds row_valid/row_idx until
// row_ready. Neither ready depends combinationally on its own valid.
interface mask_gen_sequencer_if #(
  parameter int ROW_W = 9
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mask_type;
  logic [4:0]       cfg_pattern_w;
  logic [7:0]       cfg_rep_pattern;
  logic [31:0]      cfg_seed;
  logic             cfg_continuous;
  logic             abort;
  logic             mg_rst_n;
  logic             mg_clk_en;
  logic [1:0]       mg_mask_type;
  logic [4:0]       mg_pattern_w;
  logic [7:0]       mg_repeated_pattern;
  logic             mg_pattern;
  logic             mg_load_pattern;
  logic             mg_rp_valid;
  logic             row_ready;
  logic             row_valid;
  logic [ROW_W-1:0] row_idx;
  logic             row_last;
  logic             frame_done;
  logic             busy;

  // Sequencer side
  modport master (
    input  cfg_valid, cfg_mask_type, cfg_pattern_w, cfg_rep_pattern, cfg_seed,
           cfg_continuous, abort, mg_rp_valid, row_ready,
    output cfg_ready, mg_rst_n, mg_clk_en, mg_mask_type, mg_pattern_w,
           mg_repeated_pattern, mg_pattern, mg_load_pattern, row_valid, row_idx,
           row_last, frame_done, busy
  );

  // Environment side (config source, generator, row consumer)
  modport slave (
    output cfg_valid, cfg_mask_type, cfg_pattern_w, cfg_rep_pattern, cfg_seed,
           cfg_continuous, abort, mg_rp_valid, row_ready,
    input  cfg_ready, mg_rst_n, mg_clk_en, mg_mask_type, mg_pattern_w,
           mg_repeated_pattern, mg_pattern, mg_load_pattern, row_valid, row_idx,
           row_last, frame_done, busy
  );
endinterface

// File: rtl/mask_gen_sequencer.sv
// Control-path sequencer for the VGA mask generator: takes one config, pulses
// the generator reset, loads the seed serially (or the repeated pattern in one
// strobe), then steps the generator one row at a time against downstream
// backpressure, counting rows to frame end and optionally looping frames.
module mask_gen_sequencer #(
  parameter int ROWS      = 480,
  parameter int SEED_BITS = 32,
  parameter int ROW_W     = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mask_gen_sequencer_if.master        bus,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MGRST = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam int               BIT_W    = (SEED_BITS > 1) ? $clog2(SEED_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SEED_BITS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [1:0]       TYPE_REP = 2'b11;

  state_t               state;
  logic                 cfg_ready_q;
  logic                 mg_rst_n_q;
  logic                 clk_en_q;
  logic                 load_q;
  logic                 pattern_q;
  logic                 frame_done_q;
  logic                 continuous_q;
  logic [1:0]           mask_type_q;
  logic [4:0]           pattern_w_q;
  logic [7:0]           rep_q;
  logic [SEED_BITS-1:0] seed_sh;
  logic [BIT_W-1:0]     bit_cnt;
  logic [ROW_W-1:0]     row_idx_q;
  logic [ROW_W-1:0]     last_row;
  logic                 is_rep;
  logic                 accept_cfg;
  logic                 accept_row;

  // The repeated-pattern mode produces a one-row frame.
  assign is_rep     = (mask_type_q == TYPE_REP);
  assign last_row   = is_rep ? '0 : LAST_ROW;
  // cfg_ready_q is only ever high while sitting in IDLE.
  assign accept_cfg = bus.cfg_valid && cfg_ready_q;
  assign accept_row = (state == S_RUN) && bus.mg_rp_valid && bus.row_ready;

  // Sequencer FSM; every output flop is loaded with the value belonging to
  // the state being entered, so outputs line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cfg_ready_q  <= 1'b0;
      mg_rst_n_q   <= 1'b0;
      clk_en_q     <= 1'b0;
      load_q       <= 1'b0;
      pattern_q    <= 1'b0;
      frame_done_q <= 1'b0;
      continuous_q <= 1'b0;
      mask_type_q  <= '0;
      pattern_w_q  <= '0;
      rep_q        <= '0;
      seed_sh      <= '0;
      bit_cnt      <= '0;
      row_idx_q    <= '0;
    end else if (state != S_IDLE && state != S_ABORT && bus.abort) begin
      // Abort wins over any row accept or frame end in the same cycle.
      state        <= S_ABORT;
      cfg_ready_q  <= 1'b0;
      mg_rst_n_q   <= 1'b0;
      clk_en_q     <= 1'b0;
      load_q       <= 1'b0;
      pattern_q    <= 1'b0;
      frame_done_q <= 1'b0;
      row_idx_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cfg_ready_q <= 1'b1;
          mg_rst_n_q  <= 1'b1;
          clk_en_q    <= 1'b0;
          if (accept_cfg) begin
            mask_type_q  <= bus.cfg_mask_type;
            pattern_w_q  <= bus.cfg_pattern_w;
            rep_q        <= bus.cfg_rep_pattern;
            seed_sh      <= bus.cfg_seed[SEED_BITS-1:0];
            continuous_q <= bus.cfg_continuous;
            cfg_ready_q  <= 1'b0;
            mg_rst_n_q   <= 1'b0;
            clk_en_q     <= 1'b1;
            bit_cnt      <= '0;
            row_idx_q    <= '0;
            state        <= S_MGRST;
          end
        end
        S_MGRST: begin
          mg_rst_n_q <= 1'b1;
          clk_en_q   <= 1'b1;
          load_q     <= 1'b1;
          pattern_q  <= is_rep ? 1'b0 : seed_sh[0];
          seed_sh    <= seed_sh >> 1;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          if (is_rep || bit_cnt == LAST_BIT) begin
            load_q    <= 1'b0;
            pattern_q <= 1'b0;
            clk_en_q  <= 1'b0;
            state     <= S_RUN;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            pattern_q <= seed_sh[0];
            seed_sh   <= seed_sh >> 1;
          end
        end
        S_RUN: begin
          if (accept_row) begin
            if (row_idx_q == last_row) begin
              row_idx_q    <= '0;
              frame_done_q <= 1'b1;
              state        <= S_DONE;
            end else begin
              row_idx_q <= row_idx_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          frame_done_q <= 1'b0;
          if (continuous_q && !is_rep) begin
            state <= S_RUN;
          end else begin
            cfg_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_ABORT: begin
          mg_rst_n_q  <= 1'b1;
          cfg_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // While running, the generator only advances when downstream can take the
  // row, so the mask it presents stays stable during a stall.
  assign bus.mg_clk_en           = clk_en_q || ((state == S_RUN) && bus.row_ready);
  assign bus.cfg_ready           = cfg_ready_q;
  assign bus.mg_rst_n            = mg_rst_n_q;
  assign bus.mg_mask_type        = mask_type_q;
  assign bus.mg_pattern_w        = pattern_w_q;
  assign bus.mg_repeated_pattern = rep_q;
  assign bus.mg_pattern          = pattern_q;
  assign bus.mg_load_pattern     = load_q;
  assign bus.row_valid           = (state == S_RUN) && bus.mg_rp_valid;
  assign bus.row_idx             = row_idx_q;
  assign bus.row_last            = bus.row_valid && (row_idx_q == last_row);
  assign bus.frame_done          = frame_done_q;
  assign bus.busy                = (state != S_IDLE);
  assign dbg_state               = state;

endmodule

// File: tb/tb_mask_gen_sequencer.sv
// Self-checking bench for mask_gen_sequencer: directed scenarios plus random
// jobs, with a transaction-level model (expected seed bits, rows per frame,
// frame counts) kept in a negedge monitor.
module tb_mask_gen_sequencer;
  localparam int ROWS      = 480;
  localparam int SEED_BITS = 32;
  localparam int ROW_W     = 9;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  mask_gen_sequencer_if #(.ROW_W(ROW_W)) bus ();

  mask_gen_sequencer #(.ROWS(ROWS), .SEED_BITS(SEED_BITS), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached, state=%0d", dbg_state);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int      n_checks = 0;
  int      n_pass   = 0;
  logic    exp_q[$];
  int      cyc = 0;
  int      done_cyc = 0;
  int      exp_idx = 0;
  int      frames_job = 0;
  int      loads_seen = 0;
  int      rst_low = 0;
  int      m_last = 0;
  logic [1:0] m_type = '0;
  logic [4:0] m_pw = '0;
  logic [7:0] m_rep = '0;
  bit      t5_armed = 0;
  int      ready_mode = 0;
  logic    exp_bit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_idx    = 0;
    frames_job = 0;
    loads_seen = 0;
    rst_low    = 0;
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.cfg_valid && bus.busy) chk("cfg_ready_busy", bus.cfg_ready, 0);
      if (bus.cfg_valid && bus.cfg_ready) begin
        model_clear();
        m_type = bus.cfg_mask_type;
        m_pw   = bus.cfg_pattern_w;
        m_rep  = bus.cfg_rep_pattern;
        m_last = (m_type == 2'b11) ? 0 : ROWS - 1;
        if (m_type != 2'b11)
          for (int i = 0; i < SEED_BITS; i++) exp_q.push_back(bus.cfg_seed[i]);
        if (t5_armed) begin
          chk("t5_accept_gap", cyc - done_cyc, 1);
          t5_armed = 0;
        end
      end
      if (!bus.mg_rst_n && bus.busy) rst_low++;
      if (bus.mg_load_pattern) begin
        loads_seen++;
        if (m_type != 2'b11) begin
          if (exp_q.size() == 0) chk("load_extra", 1, 0);
          else begin
            exp_bit = exp_q.pop_front();
            chk("seed_bit", bus.mg_pattern, exp_bit);
          end
        end
      end
      if (bus.row_valid) chk("clk_en_ready", bus.mg_clk_en, bus.row_ready);
      if (bus.row_valid && bus.row_ready) begin
        chk("row_idx", bus.row_idx, exp_idx);
        chk("row_last", bus.row_last, (exp_idx == m_last));
        exp_idx++;
      end
      if (bus.frame_done) begin
        chk("frame_rows", exp_idx, m_last + 1);
        chk("frame_loads", loads_seen, (m_type == 2'b11) ? 1 : SEED_BITS);
        chk("frame_rst_low", rst_low, 1);
        chk("frame_mtype", bus.mg_mask_type, m_type);
        chk("frame_pw", bus.mg_pattern_w, m_pw);
        chk("frame_rep", bus.mg_repeated_pattern, m_rep);
        frames_job++;
        exp_idx  = 0;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  // Generator row-valid and downstream ready, changed just after each edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) bus.row_ready = 1'b1;
      else if (ready_mode == 1) bus.row_ready = !bus.row_ready;
      else bus.row_ready = 1'($urandom_range(0, 1));
      bus.mg_rp_valid = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_cfg(input logic [1:0] t, input logic [4:0] pw, input logic [7:0] rep,
                          input logic [31:0] seed, input logic cont);
    bit got = 0;
    @(posedge clk); #1;
    bus.cfg_mask_type   = t;
    bus.cfg_pattern_w   = pw;
    bus.cfg_rep_pattern = rep;
    bus.cfg_seed        = seed;
    bus.cfg_continuous  = cont;
    bus.cfg_valid       = 1'b1;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      got = bus.cfg_ready;
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    chk("cfg_accept_in_time", got, 1);
    if (got) begin
      @(negedge clk);
      chk("mgrst_rst_n", bus.mg_rst_n, 0);
      chk("mgrst_clk_en", bus.mg_clk_en, 1);
      chk("mgrst_busy", bus.busy, 1);
      @(negedge clk);
      chk("load_first", bus.mg_load_pattern, 1);
      chk("load_rst_n", bus.mg_rst_n, 1);
      chk("load_clk_en", bus.mg_clk_en, 1);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = !bus.busy;
    end
    if (!ok) $display("FAIL %s_timeout: still busy, state=%0d", tag, dbg_state);
    chk({tag, "_idle"}, ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mg_rst_n"}, bus.mg_rst_n, 0);
    chk({tag, "_outs"}, {bus.cfg_ready, bus.mg_clk_en, bus.mg_mask_type, bus.mg_pattern_w,
                         bus.mg_repeated_pattern, bus.mg_pattern, bus.mg_load_pattern,
                         bus.row_valid, bus.row_idx, bus.row_last, bus.frame_done, bus.busy}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    logic [1:0] rt;
    rst_n = 1'b0;
    bus.cfg_valid = 0; bus.cfg_mask_type = 0; bus.cfg_pattern_w = 0; bus.cfg_rep_pattern = 0;
    bus.cfg_seed = 0; bus.cfg_continuous = 0; bus.abort = 0; bus.mg_rp_valid = 0; bus.row_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    chk("idle_cfg_ready", bus.cfg_ready, 1);
    chk("idle_mg_rst_n", bus.mg_rst_n, 1);

    // T1: random type, known seed, ready always high
    ready_mode = 0;
    send_cfg(2'b10, 5'd7, 8'h00, 32'h03D0A052, 1'b0);
    wait_idle("t1");
    chk("t1_frames", frames_job, 1);

    // T2: repeated pattern, one-row frame
    send_cfg(2'b11, 5'd8, 8'hAF, 32'h0, 1'b0);
    wait_idle("t2");
    chk("t2_frames", frames_job, 1);
    chk("t2_loads", loads_seen, 1);

    // T3: ready toggling every cycle
    ready_mode = 1;
    send_cfg(2'b00, 5'd3, 8'h12, $urandom, 1'b0);
    wait_idle("t3");
    chk("t3_frames", frames_job, 1);

    // T4: continuous frames, abort in frame 4 at row 100
    ready_mode = 0;
    send_cfg(2'b01, 5'd9, 8'h34, $urandom, 1'b1);
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (frames_job == 3) && (exp_idx >= 100);
    end
    chk("t4_reach_row100", ok, 1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_rst_n", bus.mg_rst_n, 0);
    chk("t4_abort_clk_en", bus.mg_clk_en, 0);
    chk("t4_abort_busy", bus.busy, 1);
    chk("t4_abort_no_done", bus.frame_done, 0);
    @(negedge clk);
    chk("t4_idle_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    chk("t4_frames", frames_job, 3);

    // T5: new config offered while running
    ready_mode = 2;
    fork
      send_cfg(2'b10, 5'd4, 8'h56, $urandom, 1'b0);
    join
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (exp_idx >= 50);
    end
    chk("t5_reach_row50", ok, 1);
    t5_armed = 1;
    send_cfg(2'b11, 5'd2, 8'h5A, 32'h0, 1'b0);
    chk("t5_armed_consumed", t5_armed, 0);
    wait_idle("t5");
    chk("t5_frames", frames_job, 1);

    // T6: reset during load bit 17
    ready_mode = 0;
    send_cfg(2'b00, 5'd1, 8'h99, $urandom, 1'b0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (loads_seen == 18);
    end
    chk("t6_reach_bit17", ok, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check_reset_outputs("t6");
    @(negedge clk);
    chk("t6_idle_cfg_ready", bus.cfg_ready, 1);
    repeat (3) @(negedge clk);
    chk("t6_no_done", frames_job, 0);

    // Random jobs
    for (int j = 0; j < 3; j++) begin
      ready_mode = $urandom_range(0, 2);
      rt = 2'($urandom_range(0, 3));
      send_cfg(rt, 5'($urandom), 8'($urandom), $urandom,
               (rt == 2'b11) ? 1'($urandom_range(0, 1)) : 1'b0);
      wait_idle("rand");
      chk("rand_frames", frames_job, 1);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
